// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM encoding and index helpers for the
// parallel time-decimation FFT front end.
package fft_pkg;

  // Default build dimensions.
  localparam int DEF_SAMPLE_W  = 32;
  localparam int DEF_LANES     = 8;
  localparam int DEF_FRAME_LEN = 64;

  // Index widths derived from the defaults.
  localparam int DEF_WORDS  = DEF_FRAME_LEN / DEF_LANES;
  localparam int LANE_IDX_W = $clog2(DEF_LANES);
  localparam int WORD_IDX_W = (DEF_WORDS > 1) ? $clog2(DEF_WORDS) : 1;

  // Packer FSM: waiting for a start-of-frame, or filling words of a frame.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Reverse the low 'width' bits of idx. Used to place samples in
  // decimation-in-time order within a word.
  function automatic int unsigned bitrev_idx(input int unsigned idx,
                                             input int unsigned width);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        r = (r << 1) | ((idx >> i) & 32'd1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_packer.sv
// fft_input_packer: serial-to-parallel front end of the parallel FFT.
// Collects one complex sample per valid cycle into a LANES-wide word and
// emits each completed word as a one-cycle pulse with frame markers.
// There is no backpressure: every accepted sample is consumed.
//
// Optional build macro FFT_INPUT_BITREV_EN: when defined, the sample at
// position p within a word lands in lane bitrev(p) (decimation-in-time
// input order). When undefined, position p lands in lane p.
module fft_input_packer
  import fft_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int LANES     = DEF_LANES,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic [SAMPLE_W-1:0]       in_data,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [SAMPLE_W*LANES-1:0] out_data,
  output logic                      err_frame
);

  localparam int OUT_W  = SAMPLE_W * LANES;
  localparam int WORDS  = FRAME_LEN / LANES;
  localparam int LIDX_W = $clog2(LANES);
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [LIDX_W-1:0]   lane_cnt;
  logic [LIDX_W-1:0]   lane_nxt;
  logic [WIDX_W-1:0]   word_cnt;
  logic [WIDX_W-1:0]   word_nxt;
  logic [OUT_W-1:0]    word_buf;
  logic [OUT_W-1:0]    word_merged;
  logic [LIDX_W-1:0]   wr_pos;
  logic [LIDX_W-1:0]   wr_lane;
  logic                wr_en;
  logic                restart;
  logic                violation;
  logic                word_done;
  logic                last_lane;
  logic                last_word;

  assign restart   = in_valid & in_sop;
  assign last_lane = (lane_cnt == LIDX_W'(LANES - 1));
  assign last_word = (word_cnt == WIDX_W'(WORDS - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a sop starts (or restarts) a frame; the last sample of the
  // eop word returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (restart) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (in_valid && !in_sop && last_lane && last_word) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: write strobe/position, counter updates, word completion
  // and framing violations. A sop always restarts at position 0, aborting
  // any partial word without emitting it.
  always_comb begin
    wr_en     = 1'b0;
    wr_pos    = lane_cnt;
    violation = 1'b0;
    word_done = 1'b0;
    lane_nxt  = lane_cnt;
    word_nxt  = word_cnt;
    case (state)
      IDLE: begin
        if (restart) begin
          wr_en    = 1'b1;
          wr_pos   = '0;
          lane_nxt = LIDX_W'(1);
          word_nxt = '0;
        end else if (in_valid) begin
          violation = 1'b1;
        end
      end
      FILL: begin
        if (restart) begin
          violation = 1'b1;
          wr_en     = 1'b1;
          wr_pos    = '0;
          lane_nxt  = LIDX_W'(1);
          word_nxt  = '0;
        end else if (in_valid) begin
          wr_en    = 1'b1;
          wr_pos   = lane_cnt;
          lane_nxt = lane_cnt + LIDX_W'(1);
          if (last_lane) begin
            word_done = 1'b1;
            word_nxt  = last_word ? '0 : word_cnt + WIDX_W'(1);
          end
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Map the write position onto a physical lane.
  always_comb begin
`ifdef FFT_INPUT_BITREV_EN
    wr_lane = LIDX_W'(bitrev_idx(32'(wr_pos), 32'(LIDX_W)));
`else
    wr_lane = wr_pos;
`endif
  end

  // The word buffer with the incoming sample dropped into its lane; this is
  // both the next buffer contents and, on completion, the emitted word.
  always_comb begin
    word_merged = word_buf;
    for (int k = 0; k < LANES; k++) begin
      if (wr_lane == LIDX_W'(k)) begin
        word_merged[k*SAMPLE_W +: SAMPLE_W] = in_data;
      end
    end
  end

  // Lane/word counters and the partial word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      word_cnt <= '0;
      word_buf <= '0;
    end else begin
      lane_cnt <= lane_nxt;
      word_cnt <= word_nxt;
      if (wr_en) begin
        word_buf <= word_merged;
      end
    end
  end

  // Registered outputs: one-cycle pulses, and out_data held between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      err_frame <= 1'b0;
    end else begin
      out_valid <= word_done;
      out_sop   <= word_done && (word_cnt == '0);
      out_eop   <= word_done && last_word;
      err_frame <= violation;
      if (word_done) begin
        out_data <= word_merged;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_packer.sv
// tb_fft_input_packer: self-checking bench for fft_input_packer.
// Works for both the natural and the FFT_INPUT_BITREV_EN builds.
module tb_fft_input_packer;
  import fft_pkg::*;

  localparam int SW = 32;
  localparam int NL = 8;
  localparam int FL = 64;
  localparam int NW = FL / NL;
  localparam int OW = SW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sop;
  logic [SW-1:0] in_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [OW-1:0] out_data;
  logic          err_frame;

  fft_input_packer #(
    .SAMPLE_W (SW),
    .LANES    (NL),
    .FRAME_LEN(FL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_data (out_data),
    .err_frame(err_frame)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  typedef struct {
    bit            r;
    bit            v;
    bit            s;
    logic [SW-1:0] d;
    bit            exp_valid;
    bit            exp_err;
  } vec_t;

  word_t         sb_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            m_fill = 1'b0;
  int            m_lane = 0;
  int            m_word = 0;
  logic [OW-1:0] m_buf = '0;
  logic [OW-1:0] last_data = '0;
  logic [OW-1:0] sop_word = '0;
  vec_t          vecs[7];
  int            nat_l[NL] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int            rev_l[NL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Lane in which the sample at word position p is expected to land.
  function automatic int tb_lane(input int p);
    int r;
`ifdef FFT_INPUT_BITREV_EN
    r = 0;
    for (int i = 0; i < $clog2(NL); i++) r = (r << 1) | ((p >> i) & 1);
`else
    r = p;
`endif
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs just after an edge against the scoreboard.
  task automatic checkOutput(input bit exp_err);
    word_t w;
    bit    exp_v;
    check_bit("err_frame", err_frame, exp_err);
    exp_v = (sb_q.size() > 0);
    check_bit("out_valid", out_valid, exp_v);
    if (exp_v) begin
      w = sb_q.pop_front();
      if (out_valid) begin
        check_word("out_data", out_data, w.data);
        check_bit("out_sop", out_sop, w.sop);
        check_bit("out_eop", out_eop, w.eop);
        if (w.sop) sop_word = w.data;
      end
      last_data = w.data;
    end else begin
      check_bit("out_sop_idle", out_sop, 1'b0);
      check_bit("out_eop_idle", out_eop, 1'b0);
      check_word("out_data_hold", out_data, last_data);
    end
  endtask

  // Drive one cycle of input, advance the reference model, and check.
  task automatic applyStimulus(input bit r, input bit v, input bit s, input logic [SW-1:0] d);
    bit    exp_err;
    word_t w;
    exp_err  = 1'b0;
    rst      = r;
    in_valid = v;
    in_sop   = s;
    in_data  = d;
    if (r) begin
      m_fill = 1'b0;
      m_lane = 0;
      m_word = 0;
      m_buf  = '0;
      sb_q.delete();
      last_data = '0;
    end else if (v) begin
      if (s) begin
        exp_err = m_fill;
        m_fill  = 1'b1;
        m_lane  = 0;
        m_word  = 0;
      end else if (!m_fill) begin
        exp_err = 1'b1;
      end
      if (m_fill) begin
        m_buf[tb_lane(m_lane)*SW +: SW] = d;
        if (m_lane == NL - 1) begin
          w.data = m_buf;
          w.sop  = (m_word == 0);
          w.eop  = (m_word == NW - 1);
          sb_q.push_back(w);
          m_lane = 0;
          if (m_word == NW - 1) begin
            m_word = 0;
            m_fill = 1'b0;
          end else begin
            m_word++;
          end
        end else begin
          m_lane++;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput(exp_err);
  endtask

  // Send n consecutive sample values starting at base, optional idle gaps.
  task automatic send_frame(input int base, input int n, input int gap, input bit with_sop);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, with_sop && (i == 0), SW'(base + i));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Word 0 of a frame based at 0 must hold the expected sample per lane.
  task automatic check_first_word(input string name);
    for (int k = 0; k < NL; k++) begin
`ifdef FFT_INPUT_BITREV_EN
      check_word(name, OW'(sop_word[k*SW +: SW]), OW'(rev_l[k]));
`else
      check_word(name, OW'(sop_word[k*SW +: SW]), OW'(nat_l[k]));
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h101, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b0};

    // Reset state: everything zero.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hdead);
    check_word("rst_out_data", out_data, '0);
    check_bit("rst_out_valid", out_valid, 1'b0);

    // Samples without sop after reset: one error pulse each, no words.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
      check_bit("tbl_out_valid", out_valid, vecs[i].exp_valid);
      check_bit("tbl_err_frame", err_frame, vecs[i].exp_err);
    end

    // Full frame of samples 0..63.
    send_frame(0, FL, 0, 1'b1);
    idle(3);
    check_first_word("frame0_lane");

    // Back-to-back frames with no gap.
    send_frame(1000, FL, 0, 1'b1);
    send_frame(2000, FL, 0, 1'b1);
    idle(2);

    // in_valid every other cycle.
    send_frame(0, FL, 1, 1'b1);
    idle(2);
    check_first_word("gapped_lane");

    // Second sop after sample 20 aborts the partial word 2.
    send_frame(3000, 20, 0, 1'b1);
    send_frame(4000, FL, 0, 1'b1);
    idle(2);

    // sop arriving when the last lane is due aborts without emitting.
    send_frame(5000, NL + NL - 1, 0, 1'b1);
    send_frame(6000, FL, 0, 1'b1);
    idle(2);

    // Reset on sample 37, then a fresh frame.
    send_frame(7000, 37, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd7037);
    check_word("midrst_out_data", out_data, '0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_err", err_frame, 1'b0);
    idle(1);
    send_frame(0, FL, 0, 1'b1);
    idle(3);
    check_first_word("postrst_lane");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
